ps2_cmd_arbiter: RTL and testbench
==================================

# ps2_cmd_arbiter

Shares the PS/2 transmitter/receiver pair between two command requesters. Slot 0 is the mouse init/stream state machine and slot 1 is the host configuration port, e.g. set sample rate F3+arg or set resolution E8+arg. For each granted request the block sequences the command byte, an optional argument byte, the FA acknowledge for each byte, FE-resend retries and timeouts, then reports one completion status. It sits between the requesters and the transmitter/receiver; no requester drives SEND_BYTE or READ_ENABLE directly.

## Interface
- MAX_RETRY, 3: FE resends allowed per byte before a NACK status.
- TIMEOUT_CYCLES, 2000000: cycles allowed in each wait state (20 ms at 100 MHz).
- TW, 21: timeout counter width; TW bits must hold TIMEOUT_CYCLES.
- Reset and clock (already decided): reset RESET, synchronous, active-high; clock CLK.
- CLK  in  1  system clock
- RESET  in  1  synchronous active-high reset
- REQ  in  2  per-slot request; hold high until DONE
- HAS_ARG  in  2  per-slot flag: the argument byte follows the command
- CMD0, ARG0  in  8 each  slot 0 command and argument bytes
- CMD1, ARG1  in  8 each  slot 1 command and argument bytes
- GNT  out  2  one-hot owner; high from grant through the DONE cycle
- DONE  out  1  one-cycle completion pulse
- STATUS  out  2  valid with DONE: 00 OK, 01 NACK, 10 TIMEOUT, 11 RXERR
- SEND_BYTE  out  1  transmitter start pulse
- BYTE_TO_SEND  out  8  transmitter data
- BYTE_SENT  in  1  transmitter done
- READ_ENABLE  out  1  receiver enable
- BYTE_READ  in  8  received byte
- BYTE_ERROR_CODE  in  2  receiver error; 00 means clean
- BYTE_READY  in  1  received byte valid, one cycle

## Operation
- States: IDLE, SEND, WAIT_SENT, WAIT_ACK, FINISH. A phase bit selects the command byte (phase 0) or the argument byte (phase 1).
- IDLE: if any REQ bit is set, pick the winner, set GNT to it, latch its CMD/ARG/HAS_ARG, clear phase and the retry count, and go to SEND.
- SEND: SEND_BYTE=1 for exactly this cycle. BYTE_TO_SEND is CMD (phase 0) or ARG (phase 1) and stays stable until the next SEND. Go to WAIT_SENT.
- WAIT_SENT: on BYTE_SENT go to WAIT_ACK. BYTE_READY seen here is ignored.
- WAIT_ACK: READ_ENABLE=1 throughout. Action on BYTE_READY:
  - BYTE_ERROR_CODE≠00: STATUS=RXERR, go to FINISH.
  - FA: if phase 0 and HAS_ARG, set phase 1, clear retry count, go to SEND. Otherwise STATUS=OK, go to FINISH.
  - FE: if retry count < MAX_RETRY, increment it and go to SEND, resending the same byte. Otherwise STATUS=NACK, go to FINISH.
  - Any other byte: STATUS=RXERR, go to FINISH.
- Timeout counter: cleared on entry to WAIT_SENT and to WAIT_ACK, incremented every cycle in those states. Reaching TIMEOUT_CYCLES gives STATUS=TIMEOUT and goes to FINISH. A byte event in the same cycle as the limit takes priority over the timeout.
- FINISH: DONE=1 for one cycle, GNT still set. Next cycle: GNT=00, state IDLE.
- The latched payload is used, so requester inputs may change after grant without effect. REQ still high in IDLE is treated as a new request.
- Reset mid-operation: return to IDLE immediately. No DONE is issued; the aborted requester re-requests.

## Timing
- All outputs are registered. Reset values: GNT=00, DONE=0, STATUS=00, SEND_BYTE=0, BYTE_TO_SEND=00, READ_ENABLE=0.
- REQ sampled high at edge N (IDLE): GNT valid after edge N, SEND_BYTE high in the cycle after edge N+1.
- BYTE_SENT at edge M: READ_ENABLE high from edge M+1.
- Final BYTE_READY at edge K: DONE and STATUS high in the cycle after edge K+1. IDLE is re-entered after edge K+2.
- Minimum REQ-to-DONE for a command with no argument, given instant transmitter/receiver responses: 5 cycles.
- Back-to-back requests: a new grant is issued at the earliest one cycle after DONE.

## Configuration
- ROUND_ROBIN_EN defined: two-slot round robin. The last-granted slot gets lower priority on the next contention. Pointer reset value favours slot 0.
- ROUND_ROBIN_EN undefined: fixed priority, slot 0 always wins.

## Structure
- Shared package holds:
  - state encoding;
  - STATUS codes (ST_OK, ST_NACK, ST_TIMEOUT, ST_RXERR);
  - PS/2 byte constants: ACK FA, RESEND FE, ENABLE F4, SET_RATE F3, SET_RES E8.
- One natural sub-module: ps2_arb_grant. It is the combinational winner selection plus the round-robin pointer register (the pointer exists only under ROUND_ROBIN_EN).

## Test plan
- Slot 1: CMD F4, no argument; transmitter answers BYTE_SENT after 10 cycles, receiver answers FA with code 00 → one SEND_BYTE with F4, GNT=10 throughout, DONE with STATUS=00.
- Slot 0: F3 with argument 64 → BYTE_TO_SEND F3 then 64, two FA acknowledges, DONE with STATUS=00.
- Receiver answers FE four times with MAX_RETRY=3 → four SEND_BYTE pulses of the same byte, then DONE with STATUS=01.
- No BYTE_SENT with TIMEOUT_CYCLES=100 → DONE with STATUS=10 exactly 100 cycles after WAIT_SENT entry.
- Contention:
  - Both REQ bits held high continuously: ROUND_ROBIN_EN undefined → GNT=01 every time; ROUND_ROBIN_EN defined → grants alternate 01, 10, 01.
  - BYTE_READY returns FC → STATUS=11.
  - Any code≠00 → STATUS=11.
- RESET asserted in WAIT_ACK → the next cycle shows all outputs at their reset values and no DONE pulse.

Source files
------------

// File: rtl/ps2_cmd_arbiter_pkg.sv
// Shared definitions for the PS/2 command arbiter: FSM encoding, completion
// status codes and the PS/2 device byte values the sequencer recognises.
package ps2_cmd_arbiter_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_SEND      = 3'd1,
    S_WAIT_SENT = 3'd2,
    S_WAIT_ACK  = 3'd3,
    S_FINISH    = 3'd4
  } state_t;

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_NACK    = 2'b01;
  localparam logic [1:0] ST_TIMEOUT = 2'b10;
  localparam logic [1:0] ST_RXERR   = 2'b11;

  localparam logic [7:0] PS2_ACK      = 8'hFA;
  localparam logic [7:0] PS2_RESEND   = 8'hFE;
  localparam logic [7:0] PS2_ENABLE   = 8'hF4;
  localparam logic [7:0] PS2_SET_RATE = 8'hF3;
  localparam logic [7:0] PS2_SET_RES  = 8'hE8;

  // Select the byte belonging to a one-hot slot (slot 1 when bit 1 is set).
  function automatic logic [7:0] slot_byte(input logic [1:0] onehot,
                                           input logic [7:0] b0,
                                           input logic [7:0] b1);
    return onehot[1] ? b1 : b0;
  endfunction

endpackage

// File: rtl/ps2_arb_grant.sv
// Winner selection between the two command requesters. With ROUND_ROBIN_EN
// a one-bit pointer demotes the last granted slot; otherwise slot 0 wins.
module ps2_arb_grant (
`ifdef ROUND_ROBIN_EN
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       take_i,
`endif
  input  logic [1:0] req_i,
  output logic [1:0] win_o
);

`ifdef ROUND_ROBIN_EN
  logic prio_q, prio_d;  // 1: slot 1 wins the next tie

  always_comb begin
    win_o  = req_i;
    if (req_i == 2'b11) win_o = prio_q ? 2'b10 : 2'b01;
    prio_d = prio_q;
    if (take_i) prio_d = win_o[0];
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) prio_q <= 1'b0;
    else         prio_q <= prio_d;
  end
`else
  always_comb begin
    win_o = 2'b00;
    if (req_i[0])      win_o = 2'b01;
    else if (req_i[1]) win_o = 2'b10;
  end
`endif

endmodule

// File: rtl/ps2_cmd_arbiter.sv
// Shares one PS/2 transmitter/receiver between two requesters and sequences
// command, optional argument, FA acks, FE resends and timeouts. ROUND_ROBIN_EN
// selects round-robin arbitration. REQ is a level held until the DONE pulse;
// SEND_BYTE/BYTE_SENT and BYTE_READY are single-cycle pulses, with no backpressure.
module ps2_cmd_arbiter
  import ps2_cmd_arbiter_pkg::*;
#(
  parameter int MAX_RETRY      = 3,
  parameter int TIMEOUT_CYCLES = 2000000,
  parameter int TW             = 21
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [1:0] REQ,
  input  logic [1:0] HAS_ARG,
  input  logic [7:0] CMD0,
  input  logic [7:0] ARG0,
  input  logic [7:0] CMD1,
  input  logic [7:0] ARG1,
  output logic [1:0] GNT,
  output logic       DONE,
  output logic [1:0] STATUS,
  output logic       SEND_BYTE,
  output logic [7:0] BYTE_TO_SEND,
  input  logic       BYTE_SENT,
  output logic       READ_ENABLE,
  input  logic [7:0] BYTE_READ,
  input  logic [1:0] BYTE_ERROR_CODE,
  input  logic       BYTE_READY,
  output logic [2:0] DBG_STATE
);

  localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

  state_t          state_q, state_d;
  logic            phase_q, phase_d;
  logic [RW-1:0]   retry_q, retry_d;
  logic [TW-1:0]   to_cnt_q, to_cnt_d;
  logic [7:0]      cmd_q, cmd_d, arg_q, arg_d;
  logic            has_arg_q, has_arg_d;
  logic [1:0]      gnt_q, gnt_d, status_q, status_d;
  logic            done_q, done_d, send_q, send_d, rd_en_q, rd_en_d;
  logic [7:0]      tx_q, tx_d;
  logic [1:0]      win;
  logic            take;
  logic            timeout;

  assign take = (state_q == S_IDLE) && (REQ != 2'b00);

  ps2_arb_grant u_grant (
`ifdef ROUND_ROBIN_EN
    .clk_i   (CLK),
    .reset_i (RESET),
    .take_i  (take),
`endif
    .req_i   (REQ),
    .win_o   (win)
  );

  // Outputs lag the state by one register stage, so the wait state is left one
  // cycle early to land DONE exactly TIMEOUT_CYCLES cycles after entry.
  assign timeout = (to_cnt_q == TW'(TIMEOUT_CYCLES - 2));

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    retry_d   = retry_q;
    to_cnt_d  = '0;
    cmd_d     = cmd_q;
    arg_d     = arg_q;
    has_arg_d = has_arg_q;
    gnt_d     = gnt_q;
    status_d  = status_q;
    send_d    = (state_q == S_SEND);
    tx_d      = (state_q == S_SEND) ? (phase_q ? arg_q : cmd_q) : tx_q;
    rd_en_d   = (state_q == S_WAIT_ACK);
    done_d    = (state_q == S_FINISH) && !done_q;
    case (state_q)
      S_IDLE: begin
        if (take) begin
          gnt_d     = win;
          cmd_d     = slot_byte(win, CMD0, CMD1);
          arg_d     = slot_byte(win, ARG0, ARG1);
          has_arg_d = |(HAS_ARG & win);
          phase_d   = 1'b0;
          retry_d   = '0;
          state_d   = S_SEND;
        end
      end
      S_SEND: state_d = S_WAIT_SENT;
      S_WAIT_SENT: begin
        if (BYTE_SENT) begin
          state_d = S_WAIT_ACK;
        end else if (timeout) begin
          status_d = ST_TIMEOUT;
          state_d  = S_FINISH;
        end else begin
          to_cnt_d = to_cnt_q + TW'(1);
        end
      end
      S_WAIT_ACK: begin
        if (BYTE_READY) begin
          state_d = S_FINISH;
          if (BYTE_ERROR_CODE != 2'b00) begin
            status_d = ST_RXERR;
          end else if (BYTE_READ == PS2_ACK) begin
            if (!phase_q && has_arg_q) begin
              phase_d = 1'b1;
              retry_d = '0;
              state_d = S_SEND;
            end else begin
              status_d = ST_OK;
            end
          end else if (BYTE_READ == PS2_RESEND) begin
            if (retry_q < RW'(MAX_RETRY)) begin
              retry_d = retry_q + RW'(1);
              state_d = S_SEND;
            end else begin
              status_d = ST_NACK;
            end
          end else begin
            status_d = ST_RXERR;
          end
        end else if (timeout) begin
          status_d = ST_TIMEOUT;
          state_d  = S_FINISH;
        end else begin
          to_cnt_d = to_cnt_q + TW'(1);
        end
      end
      S_FINISH: begin
        // Hold FINISH through the registered DONE cycle so GNT covers it.
        if (done_q) begin
          gnt_d   = 2'b00;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= S_IDLE;
      phase_q   <= 1'b0;
      retry_q   <= '0;
      to_cnt_q  <= '0;
      cmd_q     <= 8'h00;
      arg_q     <= 8'h00;
      has_arg_q <= 1'b0;
      gnt_q     <= 2'b00;
      status_q  <= ST_OK;
      done_q    <= 1'b0;
      send_q    <= 1'b0;
      rd_en_q   <= 1'b0;
      tx_q      <= 8'h00;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      retry_q   <= retry_d;
      to_cnt_q  <= to_cnt_d;
      cmd_q     <= cmd_d;
      arg_q     <= arg_d;
      has_arg_q <= has_arg_d;
      gnt_q     <= gnt_d;
      status_q  <= status_d;
      done_q    <= done_d;
      send_q    <= send_d;
      rd_en_q   <= rd_en_d;
      tx_q      <= tx_d;
    end
  end

  assign GNT          = gnt_q;
  assign DONE         = done_q;
  assign STATUS       = status_q;
  assign SEND_BYTE    = send_q;
  assign BYTE_TO_SEND = tx_q;
  assign READ_ENABLE  = rd_en_q;
  assign DBG_STATE    = state_q;

endmodule

// File: tb/tb_ps2_cmd_arbiter.sv
// Randomised bench for ps2_cmd_arbiter: a transaction-level model predicts the
// transmitted byte list and final status from the acknowledge sequence.
module tb_ps2_cmd_arbiter;

  localparam int MAXR = 3;
  localparam int TOUT = 100;
  localparam logic [1:0] E_OK = 2'b00, E_NACK = 2'b01, E_TOUT = 2'b10, E_RXERR = 2'b11;

  logic       CLK = 1'b0;
  logic       RESET;
  logic [1:0] REQ, HAS_ARG;
  logic [7:0] CMD0, ARG0, CMD1, ARG1;
  logic [1:0] GNT;
  logic       DONE;
  logic [1:0] STATUS;
  logic       SEND_BYTE;
  logic [7:0] BYTE_TO_SEND;
  logic       BYTE_SENT;
  logic       READ_ENABLE;
  logic [7:0] BYTE_READ;
  logic [1:0] BYTE_ERROR_CODE;
  logic       BYTE_READY;
  logic [2:0] dbg_state;

  int tests_run = 0;
  int tests_failed = 0;

  logic [7:0] exp_q[$];
  logic [7:0] obs_q[$];
  logic [7:0] rsp_byte_q[$];
  logic [1:0] rsp_code_q[$];
  logic [1:0] exp_status;
  logic [1:0] obs_status, obs_gnt;
  bit         obs_done, obs_gnt_stable;
  int         first_send_cyc, done_cyc;

  ps2_cmd_arbiter #(.MAX_RETRY(MAXR), .TIMEOUT_CYCLES(TOUT), .TW(21)) dut (
    .CLK(CLK), .RESET(RESET), .REQ(REQ), .HAS_ARG(HAS_ARG),
    .CMD0(CMD0), .ARG0(ARG0), .CMD1(CMD1), .ARG1(ARG1),
    .GNT(GNT), .DONE(DONE), .STATUS(STATUS),
    .SEND_BYTE(SEND_BYTE), .BYTE_TO_SEND(BYTE_TO_SEND), .BYTE_SENT(BYTE_SENT),
    .READ_ENABLE(READ_ENABLE), .BYTE_READ(BYTE_READ),
    .BYTE_ERROR_CODE(BYTE_ERROR_CODE), .BYTE_READY(BYTE_READY),
    .DBG_STATE(dbg_state)
  );

  always #5 CLK = ~CLK;

  // Runs one granted request as transmitter/receiver; responses come from rsp_*_q.
  task automatic run_txn(input logic [1:0] req_mask, input int sent_delay, input bit keep_req);
    int cyc = 0;
    int sent_cd = 0;
    int rx_cd = 0;
    bit armed = 0;
    bit granted = 0;
    obs_q.delete();
    obs_done = 0; obs_gnt = 2'b00; obs_gnt_stable = 1; obs_status = 2'b00;
    first_send_cyc = -1; done_cyc = -1;
    REQ = req_mask;
    while (cyc < 1000) begin
      @(negedge CLK);
      cyc++;
      BYTE_SENT = 1'b0; BYTE_READY = 1'b0; BYTE_ERROR_CODE = 2'b00;
      if (!granted && GNT != 2'b00) begin
        granted = 1; obs_gnt = GNT;
        CMD0 = 8'($urandom); CMD1 = 8'($urandom);
        ARG0 = 8'($urandom); ARG1 = 8'($urandom); HAS_ARG = 2'($urandom);
      end else if (granted && GNT !== obs_gnt) begin
        obs_gnt_stable = 0;
      end
      if (DONE === 1'b1) begin
        obs_done = 1; obs_status = STATUS; done_cyc = cyc;
        break;
      end
      if (SEND_BYTE === 1'b1) begin
        obs_q.push_back(BYTE_TO_SEND);
        if (first_send_cyc < 0) first_send_cyc = cyc;
        sent_cd = sent_delay; armed = 1; rx_cd = $urandom_range(0, 3);
      end else if (sent_cd > 0) begin
        sent_cd--;
        if (sent_cd == 0) BYTE_SENT = 1'b1;
        else if ($urandom_range(0, 7) == 0) begin
          BYTE_READY = 1'b1; BYTE_READ = 8'hFC; BYTE_ERROR_CODE = 2'b01;
        end
      end else if (armed && READ_ENABLE === 1'b1 && rsp_byte_q.size() > 0) begin
        if (rx_cd > 0) rx_cd--;
        else begin
          BYTE_READY = 1'b1;
          BYTE_READ = rsp_byte_q.pop_front();
          BYTE_ERROR_CODE = rsp_code_q.pop_front();
          armed = 0;
        end
      end
    end
    if (!keep_req) REQ = 2'b00;
  endtask

  // Reference model: walks a random acknowledge sequence through the protocol rules.
  task automatic build_case(input logic [7:0] cmd, input logic [7:0] arg, input logic has_arg);
    int nb = has_arg ? 2 : 1;
    int idx = 0;
    int retries = 0;
    bit fin = 0;
    logic [7:0] b;
    logic [1:0] code;
    exp_q.delete(); rsp_byte_q.delete(); rsp_code_q.delete();
    while (!fin) begin
      int roll = $urandom_range(0, 99);
      code = 2'b00;
      if (roll < 60) b = 8'hFA;
      else if (roll < 85) b = 8'hFE;
      else if (roll < 93) begin
        b = 8'($urandom);
        if (b == 8'hFA || b == 8'hFE) b = 8'h00;
      end else begin
        b = 8'hFA; code = 2'($urandom_range(1, 3));
      end
      exp_q.push_back(idx == 0 ? cmd : arg);
      rsp_byte_q.push_back(b); rsp_code_q.push_back(code);
      if (code != 2'b00) begin exp_status = E_RXERR; fin = 1; end
      else if (b == 8'hFA) begin
        idx++; retries = 0;
        if (idx == nb) begin exp_status = E_OK; fin = 1; end
      end else if (b == 8'hFE) begin
        if (retries < MAXR) retries++;
        else begin exp_status = E_NACK; fin = 1; end
      end else begin exp_status = E_RXERR; fin = 1; end
    end
  endtask

  task automatic test_reset();
    RESET = 1'b1; REQ = 2'b00; HAS_ARG = 2'b00;
    CMD0 = 8'h00; ARG0 = 8'h00; CMD1 = 8'h00; ARG1 = 8'h00;
    BYTE_SENT = 1'b0; BYTE_READ = 8'h00; BYTE_ERROR_CODE = 2'b00; BYTE_READY = 1'b0;
    repeat (3) @(negedge CLK);
    RESET = 1'b0;
    @(negedge CLK);
    tests_run++; if (GNT !== 2'b00) begin tests_failed++; $display("FAIL reset_gnt: got %b expected 00", GNT); end
    tests_run++; if (DONE !== 1'b0) begin tests_failed++; $display("FAIL reset_done: got %b expected 0", DONE); end
    tests_run++; if (STATUS !== 2'b00) begin tests_failed++; $display("FAIL reset_status: got %b expected 00", STATUS); end
    tests_run++; if (SEND_BYTE !== 1'b0) begin tests_failed++; $display("FAIL reset_send: got %b expected 0", SEND_BYTE); end
    tests_run++; if (BYTE_TO_SEND !== 8'h00) begin tests_failed++; $display("FAIL reset_byte: got %h expected 00", BYTE_TO_SEND); end
    tests_run++; if (READ_ENABLE !== 1'b0) begin tests_failed++; $display("FAIL reset_rden: got %b expected 0", READ_ENABLE); end
  endtask

  task automatic test_slot1_enable();
    CMD1 = 8'hF4; HAS_ARG = 2'b00;
    rsp_byte_q = '{8'hFA}; rsp_code_q = '{2'b00};
    run_txn(2'b10, 10, 0);
    tests_run++; if (obs_done !== 1'b1) begin tests_failed++; $display("FAIL s1_done: got %b expected 1", obs_done); end
    tests_run++; if (obs_q.size() != 1) begin tests_failed++; $display("FAIL s1_sends: got %0d expected 1", obs_q.size()); end
    else begin tests_run++; if (obs_q[0] !== 8'hF4) begin tests_failed++; $display("FAIL s1_byte: got %h expected f4", obs_q[0]); end end
    tests_run++; if (obs_gnt !== 2'b10 || !obs_gnt_stable) begin tests_failed++; $display("FAIL s1_gnt: got %b stable %0d expected 10 stable 1", obs_gnt, obs_gnt_stable); end
    tests_run++; if (obs_status !== E_OK) begin tests_failed++; $display("FAIL s1_status: got %b expected 00", obs_status); end
    @(negedge CLK);
    tests_run++; if (GNT !== 2'b00) begin tests_failed++; $display("FAIL s1_release: got %b expected 00", GNT); end
  endtask

  task automatic test_slot0_rate();
    CMD0 = 8'hF3; ARG0 = 8'h64; HAS_ARG = 2'b01;
    rsp_byte_q = '{8'hFA, 8'hFA}; rsp_code_q = '{2'b00, 2'b00};
    run_txn(2'b01, 3, 0);
    tests_run++; if (obs_q.size() != 2) begin tests_failed++; $display("FAIL rate_sends: got %0d expected 2", obs_q.size()); end
    else begin
      tests_run++; if (obs_q[0] !== 8'hF3) begin tests_failed++; $display("FAIL rate_cmd: got %h expected f3", obs_q[0]); end
      tests_run++; if (obs_q[1] !== 8'h64) begin tests_failed++; $display("FAIL rate_arg: got %h expected 64", obs_q[1]); end
    end
    tests_run++; if (obs_status !== E_OK || !obs_done) begin tests_failed++; $display("FAIL rate_status: got %b done %0d expected 00 done 1", obs_status, obs_done); end
  endtask

  task automatic test_nack();
    CMD0 = 8'hE8; HAS_ARG = 2'b00;
    rsp_byte_q = '{8'hFE, 8'hFE, 8'hFE, 8'hFE}; rsp_code_q = '{2'b00, 2'b00, 2'b00, 2'b00};
    run_txn(2'b01, 2, 0);
    tests_run++; if (obs_q.size() != 4) begin tests_failed++; $display("FAIL nack_sends: got %0d expected 4", obs_q.size()); end
    foreach (obs_q[i]) begin
      tests_run++; if (obs_q[i] !== 8'hE8) begin tests_failed++; $display("FAIL nack_byte%0d: got %h expected e8", i, obs_q[i]); end
    end
    tests_run++; if (obs_status !== E_NACK) begin tests_failed++; $display("FAIL nack_status: got %b expected 01", obs_status); end
  endtask

  task automatic test_timeouts();
    rsp_byte_q.delete(); rsp_code_q.delete();
    CMD1 = 8'hF4; HAS_ARG = 2'b00;
    run_txn(2'b10, -1, 0);
    tests_run++; if (obs_status !== E_TOUT || !obs_done) begin tests_failed++; $display("FAIL tsent_status: got %b done %0d expected 10 done 1", obs_status, obs_done); end
    tests_run++; if (done_cyc - first_send_cyc != TOUT) begin tests_failed++; $display("FAIL tsent_cycles: got %0d expected %0d", done_cyc - first_send_cyc, TOUT); end
    // BYTE_SENT on the last allowed cycle wins over the timeout; one cycle later loses.
    CMD1 = 8'hF4; HAS_ARG = 2'b00;
    rsp_byte_q = '{8'hFA}; rsp_code_q = '{2'b00};
    run_txn(2'b10, TOUT - 2, 0);
    tests_run++; if (obs_status !== E_OK) begin tests_failed++; $display("FAIL tedge_in: got %b expected 00", obs_status); end
    CMD1 = 8'hF4;
    rsp_byte_q = '{8'hFA}; rsp_code_q = '{2'b00};
    run_txn(2'b10, TOUT - 1, 0);
    tests_run++; if (obs_status !== E_TOUT) begin tests_failed++; $display("FAIL tedge_out: got %b expected 10", obs_status); end
    rsp_byte_q.delete(); rsp_code_q.delete();
    CMD0 = 8'hE8;
    run_txn(2'b01, 2, 0);
    tests_run++; if (obs_status !== E_TOUT || obs_q.size() != 1) begin tests_failed++; $display("FAIL tack_status: got %b sends %0d expected 10 sends 1", obs_status, obs_q.size()); end
  endtask

  task automatic test_rxerr();
    CMD0 = 8'hF4; HAS_ARG = 2'b00;
    rsp_byte_q = '{8'hFC}; rsp_code_q = '{2'b00};
    run_txn(2'b01, 1, 0);
    tests_run++; if (obs_status !== E_RXERR) begin tests_failed++; $display("FAIL rx_fc: got %b expected 11", obs_status); end
    CMD1 = 8'hF4;
    rsp_byte_q = '{8'hFA}; rsp_code_q = '{2'b10};
    run_txn(2'b10, 1, 0);
    tests_run++; if (obs_status !== E_RXERR) begin tests_failed++; $display("FAIL rx_code: got %b expected 11", obs_status); end
  endtask

  task automatic test_contention();
    logic [1:0] exp_g[3];
`ifdef ROUND_ROBIN_EN
    exp_g = '{2'b01, 2'b10, 2'b01};
`else
    exp_g = '{2'b01, 2'b01, 2'b01};
`endif
    for (int k = 0; k < 3; k++) begin
      CMD0 = 8'h11; CMD1 = 8'h22; HAS_ARG = 2'b00;
      rsp_byte_q = '{8'hFA}; rsp_code_q = '{2'b00};
      run_txn(2'b11, 2, k < 2);
      tests_run++; if (obs_gnt !== exp_g[k]) begin tests_failed++; $display("FAIL cont_gnt%0d: got %b expected %b", k, obs_gnt, exp_g[k]); end
      tests_run++; if (obs_q.size() != 1 || obs_q[0] !== (exp_g[k][1] ? 8'h22 : 8'h11)) begin
        tests_failed++; $display("FAIL cont_byte%0d: got %0d sends first %h", k, obs_q.size(), obs_q.size() > 0 ? obs_q[0] : 8'h00);
      end
    end
  endtask

  task automatic test_back_to_back();
    CMD0 = 8'hF4; HAS_ARG = 2'b00;
    rsp_byte_q = '{8'hFA}; rsp_code_q = '{2'b00};
    run_txn(2'b01, 1, 1);
    CMD0 = 8'hE8; HAS_ARG = 2'b00;
    rsp_byte_q = '{8'hFA}; rsp_code_q = '{2'b00};
    @(negedge CLK);
    tests_run++; if (GNT !== 2'b00) begin tests_failed++; $display("FAIL b2b_gap: got %b expected 00", GNT); end
    @(negedge CLK);
    tests_run++; if (GNT !== 2'b01) begin tests_failed++; $display("FAIL b2b_regrant: got %b expected 01", GNT); end
    run_txn(2'b01, 1, 0);
    tests_run++; if (obs_q.size() != 1 || obs_q[0] !== 8'hE8 || obs_status !== E_OK) begin
      tests_failed++; $display("FAIL b2b_second: got %0d sends status %b expected 1 send of e8 status 00", obs_q.size(), obs_status);
    end
  endtask

  task automatic test_reset_mid();
    int guard = 0;
    int dones = 0;
    CMD1 = 8'hF4; HAS_ARG = 2'b00; REQ = 2'b10;
    while (SEND_BYTE !== 1'b1 && guard < 50) begin @(negedge CLK); guard++; end
    BYTE_SENT = 1'b1;
    @(negedge CLK); BYTE_SENT = 1'b0;
    while (READ_ENABLE !== 1'b1 && guard < 50) begin @(negedge CLK); guard++; end
    tests_run++; if (READ_ENABLE !== 1'b1) begin tests_failed++; $display("FAIL rmid_reach: got %b expected 1", READ_ENABLE); end
    RESET = 1'b1; REQ = 2'b00;
    @(negedge CLK);
    RESET = 1'b0;
    tests_run++; if ({GNT, DONE, STATUS, SEND_BYTE, BYTE_TO_SEND, READ_ENABLE} !== 15'd0) begin
      tests_failed++; $display("FAIL rmid_outputs: got gnt %b done %b st %b send %b byte %h rden %b expected all 0",
                               GNT, DONE, STATUS, SEND_BYTE, BYTE_TO_SEND, READ_ENABLE);
    end
    repeat (10) begin @(negedge CLK); if (DONE === 1'b1) dones++; end
    tests_run++; if (dones != 0) begin tests_failed++; $display("FAIL rmid_nodone: got %0d expected 0", dones); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 30; n++) begin
      int slot = $urandom_range(0, 1);
      logic [1:0] mask = slot ? 2'b10 : 2'b01;
      logic [7:0] c = 8'($urandom);
      logic [7:0] a = 8'($urandom);
      logic h = 1'($urandom_range(0, 1));
      CMD0 = 8'($urandom); CMD1 = 8'($urandom); ARG0 = 8'($urandom); ARG1 = 8'($urandom);
      HAS_ARG = 2'($urandom);
      if (slot) begin CMD1 = c; ARG1 = a; HAS_ARG[1] = h; end
      else      begin CMD0 = c; ARG0 = a; HAS_ARG[0] = h; end
      build_case(c, a, h);
      run_txn(mask, $urandom_range(1, 6), 0);
      tests_run++; if (!obs_done || obs_status !== exp_status) begin tests_failed++; $display("FAIL rnd%0d_status: got %b done %0d expected %b", n, obs_status, obs_done, exp_status); end
      tests_run++; if (obs_gnt !== mask || !obs_gnt_stable) begin tests_failed++; $display("FAIL rnd%0d_gnt: got %b stable %0d expected %b", n, obs_gnt, obs_gnt_stable, mask); end
      tests_run++; if (obs_q.size() != exp_q.size()) begin tests_failed++; $display("FAIL rnd%0d_sends: got %0d expected %0d", n, obs_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
        tests_run++; if (obs_q[i] !== exp_q[i]) begin tests_failed++; $display("FAIL rnd%0d_byte%0d: got %h expected %h", n, i, obs_q[i], exp_q[i]); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_slot1_enable();
    test_slot0_rate();
    test_nack();
    test_timeouts();
    test_rxerr();
    test_contention();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
